sp_ram_arbiter: RTL
===================

Name: sp_ram_arbiter

Overview:
- Shares one single-port SRAM (sp_ram instance, user-side port) between NUM_REQ requesters using round-robin arbitration.
- Each requester has its own valid/ready request channel and valid/ready read-response channel. Responses are returned in order and routed by requester id.
- Sits between cache/pipeline clients and the sp_ram user interface.
- Honours a hold input so the RAM can be lent to init/BIST logic.

Parameters:
- NUM_REQ, 2, number of requesters, 2..8.
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 64, RAM data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_mask  in  NUM_REQ*DATA_WIDTH  packed bit-write mask, 1 = write bit.
- rsp_valid  out  NUM_REQ  read data valid for requester i.
- rsp_ready  in  NUM_REQ  requester i consumes response.
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters.
- ram_hold  in  1  RAM busy (init/BIST); blocks new grants.
- ram_clk_en  out  1  to sp_ram clk_en.
- ram_rdw_en  out  1  to sp_ram rdw_en, 1 = WR.
- ram_addr  out  ADDR_WIDTH  to sp_ram addr.
- ram_data_in  out  DATA_WIDTH  to sp_ram data_in.
- ram_mask  out  DATA_WIDTH  to sp_ram data_mask_in.
- ram_data_out  in  DATA_WIDTH  from sp_ram data_out; valid the cycle after a read.

Behaviour:
- Reset (async assert, sync deassert): rr_ptr=0, rd_pend=0, FIFO empty.
  - Outputs held at reset: req_ready=0, rsp_valid=0, ram_clk_en=0, ram_rdw_en=0, ram_addr/data_in/mask=0.
  - Reset during an operation discards any in-flight read and all queued responses.
- Eligibility of requester i: req_valid[i] & (req_we[i] | rd_credit).
  - rd_credit = (rd_pend + fifo_count - pop) < 2, where pop = FIFO head valid & rsp_ready[head_id].
- Grant:
  - When ram_hold=0, grant at most one eligible requester: the first eligible index at or after rr_ptr, cyclically.
  - req_ready = one-hot grant. Ready may depend on valid; valid must not depend on ready.
  - On a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- RAM drive in the grant cycle T:
  - ram_clk_en=1, ram_rdw_en=req_we[g], and addr/wdata/mask taken from slice g.
  - With no grant, ram_clk_en=0 and the other RAM outputs are 0.
  - Writes complete in cycle T and produce no response.
- Read pipeline:
  - A read granted in T sets rd_pend=1 and records id g for cycle T+1.
  - At the end of T+1, {g, ram_data_out} is pushed into a 2-entry FIFO.
  - rsp_valid[head_id]=1 from T+2, so read latency is 2 cycles.
  - rsp_data = FIFO head data. rsp_valid, rsp_data and the head entry stay stable until rsp_ready[head_id]=1.
  - rsp_ready bits of non-head requesters are ignored.
- Throughput: one access per cycle when rsp_ready is held high. Push and pop in the same cycle are allowed.
- Ordering: responses follow grant order. A read after a write to the same address, granted in a later cycle, returns the new data.
- ram_hold:
  - Blocks grants only.
  - A read issued before hold asserted is still captured at T+1.
  - The FIFO continues to drain while hold is asserted.
- Credit guarantees no FIFO overflow. A push to a full FIFO is an assertion failure.

Decomposition:
- Shared header/package: REQ_ID_WIDTH = clog2(NUM_REQ) (minimum 1), and the RSP_FIFO_DEPTH=2 constant.
- Sub-module sp_ram_arb_rsp_fifo:
  - 2-entry FIFO of {id, data} with push/pop/full/empty.
  - Same clock and async reset as the parent.
- Round-robin pick is a combinational function in the parent.

Test Plan:
- Basic write then read (NUM_REQ=2):
  - Req0 writes addr 0x10, data 0xDEAD_BEEF, full mask; then reads 0x10.
  - Expect req_ready in 1 cycle, rsp_valid[0] 2 cycles after the read grant, rsp_data=0xDEAD_BEEF.
- Fairness:
  - Req0 and req1 both hold continuous reads, rsp_ready=1.
  - Expect grants alternate 0,1,0,1 with one grant per cycle and responses in the same order.
- Backpressure:
  - Req1 issues 4 back-to-back reads with rsp_ready[1]=0.
  - Expect exactly 2 grants, then req_ready[1]=0.
  - After releasing rsp_ready, the remaining reads are granted and all 4 data words arrive in order, unchanged while stalled.
- Writes under backpressure:
  - While the FIFO is full, req0 issues writes.
  - Expect writes granted every cycle; masked write 0x00FF to data 0xAAAA over 0x5555 gives readback 0x55AA.
- ram_hold:
  - Assert hold one cycle after a read grant, for 5 cycles.
  - Expect no grants and ram_clk_en=0 during hold, the pending read still delivered, and grants resuming from rr_ptr the cycle hold drops.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously with one read pending and one response queued.
  - Expect all outputs 0 immediately, and no stale rsp_valid after reset release.

Source files
------------

// File: rtl/sp_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sp_ram_arbiter_pkg
//  Brief    : Shared constants and helpers for the single-port RAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package sp_ram_arbiter_pkg;

   // Depth of the read-response FIFO. The read credit scheme relies on it.
   localparam int RSP_FIFO_DEPTH = 2;

   // Width of the FIFO occupancy counter (must hold 0..RSP_FIFO_DEPTH).
   localparam int RSP_CNT_WIDTH = $clog2(RSP_FIFO_DEPTH + 1);

   // Requester id width: clog2(num_req), never narrower than one bit.
   function automatic int req_id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_arb_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sp_ram_arb_rsp_fifo
//  Brief    : Two-entry FIFO holding {requester id, read data} responses.
//  Revision : 1.0 - initial release
// ============================================================================
module sp_ram_arb_rsp_fifo
   import sp_ram_arbiter_pkg::*;
#(
   parameter int ID_WIDTH   = 1,
   parameter int DATA_WIDTH = 64
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [ID_WIDTH-1:0]      push_id,
   input  logic [DATA_WIDTH-1:0]    push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [RSP_CNT_WIDTH-1:0] count,
   output logic [ID_WIDTH-1:0]      head_id,
   output logic [DATA_WIDTH-1:0]    head_data
);

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   // With two entries the pointers are single bits that wrap naturally.
   entry_t                     mem_q [RSP_FIFO_DEPTH];
   entry_t                     mem_d [RSP_FIFO_DEPTH];
   logic                       rd_ptr_q, rd_ptr_d;
   logic                       wr_ptr_q, wr_ptr_d;
   logic [RSP_CNT_WIDTH-1:0]   count_q, count_d;
   logic                       do_pop;

   assign full      = (count_q == RSP_CNT_WIDTH'(RSP_FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_id   = mem_q[rd_ptr_q].id;
   assign head_data = mem_q[rd_ptr_q].data;

   // Next-state: write at the tail on push, advance the head on pop.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      do_pop   = pop & ~empty;
      if (push) begin
         mem_d[wr_ptr_q] = {push_id, push_data};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + RSP_CNT_WIDTH'(push) - RSP_CNT_WIDTH'(do_pop);
   end

   // State registers; reset empties the FIFO and clears stored entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // The parent's read credit must never let a response land on a full FIFO.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule
`default_nettype wire

// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sp_ram_arbiter
//  Brief    : Round-robin arbiter sharing one single-port SRAM between
//             NUM_REQ requesters, with in-order read responses routed by id.
//  Revision : 1.0 - initial release
// ============================================================================
module sp_ram_arbiter
   import sp_ram_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_mask,
   output logic [NUM_REQ-1:0]            rsp_valid,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   input  logic                          ram_hold,
   output logic                          ram_clk_en,
   output logic                          ram_rdw_en,
   output logic [ADDR_WIDTH-1:0]         ram_addr,
   output logic [DATA_WIDTH-1:0]         ram_data_in,
   output logic [DATA_WIDTH-1:0]         ram_mask,
   input  logic [DATA_WIDTH-1:0]         ram_data_out
);

   localparam int REQ_ID_WIDTH = req_id_width(NUM_REQ);
   localparam int INF_WIDTH    = RSP_CNT_WIDTH + 1;

   logic [REQ_ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
   logic                     rd_pend_q, rd_pend_d;
   logic [REQ_ID_WIDTH-1:0]  rd_id_q, rd_id_d;

   logic                     fifo_full, fifo_empty, fifo_pop;
   logic [RSP_CNT_WIDTH-1:0] fifo_count;
   logic [REQ_ID_WIDTH-1:0]  head_id;
   logic [DATA_WIDTH-1:0]    head_data;

   logic [INF_WIDTH-1:0]     in_flight;
   logic                     rd_credit;
   logic [NUM_REQ-1:0]       eligible;
   logic [REQ_ID_WIDTH:0]    pick;
   logic                     grant_valid;
   logic [REQ_ID_WIDTH-1:0]  grant_id;

   // First eligible index at or after ptr, cyclically; MSB flags a hit.
   function automatic logic [REQ_ID_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0]      elig,
                                                     input logic [REQ_ID_WIDTH-1:0] ptr);
      logic                    found;
      logic [REQ_ID_WIDTH-1:0] idx;
      int                      c;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         c = (int'(ptr) + k) % NUM_REQ;
         if (!found && elig[c]) begin
            found = 1'b1;
            idx   = REQ_ID_WIDTH'(c);
         end
      end
      return {found, idx};
   endfunction

   // Read credit: a new read may issue only if its response is sure to fit
   // once it reaches the FIFO, counting a pop happening this cycle.
   always_comb begin
      fifo_pop    = ~fifo_empty & rsp_ready[head_id];
      in_flight   = INF_WIDTH'(rd_pend_q) + INF_WIDTH'(fifo_count) - INF_WIDTH'(fifo_pop);
      rd_credit   = (in_flight < INF_WIDTH'(RSP_FIFO_DEPTH));
      eligible    = req_valid & (req_we | {NUM_REQ{rd_credit}});
      pick        = rr_pick(eligible, rr_ptr_q);
      // rst_n gating keeps ready and RAM strobes low while reset is asserted.
      grant_valid = rst_n & ~ram_hold & pick[REQ_ID_WIDTH];
      grant_id    = pick[REQ_ID_WIDTH-1:0];
   end

   // Grant handshake and RAM drive for the winning requester.
   always_comb begin
      req_ready   = '0;
      ram_clk_en  = 1'b0;
      ram_rdw_en  = 1'b0;
      ram_addr    = '0;
      ram_data_in = '0;
      ram_mask    = '0;
      if (grant_valid) begin
         req_ready[grant_id] = 1'b1;
         ram_clk_en          = 1'b1;
         ram_rdw_en          = req_we[grant_id];
         ram_addr            = req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
         ram_data_in         = req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
         ram_mask            = req_mask[grant_id*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Response routing: only the FIFO head's owner sees valid.
   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = ~fifo_empty & (head_id == REQ_ID_WIDTH'(i));
      end
      rsp_data = head_data;
   end

   // Next-state for the round-robin pointer and the one-deep read pipeline.
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      rd_pend_d = 1'b0;
      rd_id_d   = rd_id_q;
      if (grant_valid) begin
         rr_ptr_d  = REQ_ID_WIDTH'((int'(grant_id) + 1) % NUM_REQ);
         rd_pend_d = ~req_we[grant_id];
         rd_id_d   = grant_id;
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q  <= '0;
         rd_pend_q <= 1'b0;
         rd_id_q   <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         rd_pend_q <= rd_pend_d;
         rd_id_q   <= rd_id_d;
      end
   end

   // RAM read data arrives the cycle after the grant and is queued with its id.
   sp_ram_arb_rsp_fifo #(
      .ID_WIDTH   (REQ_ID_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (rd_pend_q),
      .push_id    (rd_id_q),
      .push_data  (ram_data_out),
      .pop        (fifo_pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count),
      .head_id    (head_id),
      .head_data  (head_data)
   );

endmodule
`default_nettype wire
